// File: rtl/free_list_pkg.sv
// Shared types and helpers for the resource free-list return path.
package free_list_pkg;

  localparam int unsigned DEFAULT_NUM_RESOURCES = 64;
  localparam int unsigned RES_IDX_W             = $clog2(DEFAULT_NUM_RESOURCES);

  typedef logic [RES_IDX_W-1:0]             resource_idx_t;
  typedef logic [DEFAULT_NUM_RESOURCES-1:0] resource_mask_t;

  // Single-bit mask with only the bit for idx set.
  function automatic resource_mask_t onehot_idx(input resource_idx_t idx);
    resource_mask_t m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/release_queue.sv
// Multi-port circular FIFO: up to NUM_IN writes per cycle (compacted in port
// order), up to NUM_OUT oldest entries presented and retired per cycle.
module release_queue #(
  parameter  int unsigned DEPTH   = 8,
  parameter  int unsigned NUM_IN  = 3,
  parameter  int unsigned NUM_OUT = 2,
  parameter  int unsigned DATA_W  = 6,
  localparam int unsigned PTR_W   = $clog2(DEPTH),
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [NUM_IN-1:0]                in_valid,
  input  logic [NUM_IN-1:0][DATA_W-1:0]    in_data,
  output logic                             in_ready,
  output logic [NUM_OUT-1:0][DATA_W-1:0]   out_data,
  output logic [CNT_W-1:0]                 out_cnt,
  output logic [CNT_W-1:0]                 count
);

  logic [DATA_W-1:0]             mem [DEPTH];
  logic [PTR_W-1:0]              head;
  logic [PTR_W-1:0]              tail;
  logic [NUM_IN-1:0][PTR_W-1:0]  wr_slot;
  logic [PTR_W-1:0]              wr_off;
  logic [CNT_W-1:0]              enq_cnt;
  logic                          push;

  // Space check uses registered count only, never this cycle's drain.
  assign in_ready = (32'(count) + NUM_IN) <= DEPTH;
  assign push     = in_ready & ~flush;
  assign out_cnt  = (count < CNT_W'(NUM_OUT)) ? count : CNT_W'(NUM_OUT);

  // Compact valid ports: k-th valid port targets tail + k.
  always_comb begin
    wr_off  = '0;
    enq_cnt = '0;
    wr_slot = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      wr_slot[i] = tail + wr_off;
      if (in_valid[i]) begin
        wr_off  = wr_off + 1'b1;
        enq_cnt = enq_cnt + 1'b1;
      end
    end
  end

  // Present the oldest NUM_OUT slots; only out_cnt of them are meaningful.
  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      out_data[i] = mem[head + PTR_W'(i)];
    end
  end

  // Storage write for accepted entries.
  always_ff @(posedge clock) begin
    if (push) begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (in_valid[i]) mem[wr_slot[i]] <= in_data[i];
      end
    end
  end

  // Pointer and occupancy update; flush discards everything queued.
  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= tail;
      count <= '0;
    end else begin
      head  <= head + out_cnt[PTR_W-1:0];
      if (push) tail <= tail + enq_cnt[PTR_W-1:0];
      count <= count + (push ? enq_cnt : '0) - out_cnt;
    end
  end

endmodule

// File: rtl/resource_reclaimer.sv
// Free-list return path: buffers retired indices, drains them as clear bits
// for the allocator and tracks the committed free mask for mispredict restore.
module resource_reclaimer #(
  parameter  int unsigned NUM_RESOURCES = free_list_pkg::DEFAULT_NUM_RESOURCES,
  parameter  int unsigned NUM_RETIRE    = 3,
  parameter  int unsigned NUM_DRAIN     = 2,
  parameter  int unsigned QUEUE_DEPTH   = 8,
  localparam int unsigned IDX_W         = $clog2(NUM_RESOURCES),
  localparam int unsigned CNT_W         = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_RETIRE-1:0]               rel_valid,
  input  logic [NUM_RETIRE-1:0][IDX_W-1:0]    rel_idx,
  output logic                                rel_ready,
  input  logic [NUM_RETIRE-1:0]               commit_valid,
  input  logic [NUM_RETIRE-1:0][IDX_W-1:0]    commit_idx,
  input  logic                                mispredict,
  input  logic [NUM_RESOURCES-1:0]            initial_mask,
  output logic [NUM_RESOURCES-1:0]            clear,
  output logic [NUM_RESOURCES-1:0]            restore_mask,
  output logic [CNT_W-1:0]                    queue_count,
  output logic                                overflow_err,
  output logic                                double_free_err
);

  logic [NUM_RESOURCES-1:0]          committed_free;
  logic [NUM_RESOURCES-1:0]          committed_free_next;
  logic [NUM_RESOURCES-1:0]          rel_mask;
  logic [NUM_RESOURCES-1:0]          commit_mask;
  logic [NUM_DRAIN-1:0][IDX_W-1:0]   drain_idx;
  logic [CNT_W-1:0]                  drain_cnt;
  logic                              dbl_hit;

  release_queue #(
    .DEPTH   (QUEUE_DEPTH),
    .NUM_IN  (NUM_RETIRE),
    .NUM_OUT (NUM_DRAIN),
    .DATA_W  (IDX_W)
  ) u_queue (
    .clock    (clock),
    .reset    (reset),
    .flush    (mispredict),
    .in_valid (rel_valid),
    .in_data  (rel_idx),
    .in_ready (rel_ready),
    .out_data (drain_idx),
    .out_cnt  (drain_cnt),
    .count    (queue_count)
  );

  // Accepted releases and commits as masks; a release hitting an already-free
  // bit (registered or earlier port this cycle) is a double free.
  always_comb begin
    rel_mask    = '0;
    commit_mask = '0;
    dbl_hit     = 1'b0;
    for (int unsigned i = 0; i < NUM_RETIRE; i++) begin
      if (rel_valid[i] && rel_ready) begin
        if (committed_free[rel_idx[i]] || rel_mask[rel_idx[i]]) dbl_hit = 1'b1;
        rel_mask[rel_idx[i]] = 1'b1;
      end
      if (commit_valid[i]) commit_mask[commit_idx[i]] = 1'b1;
    end
    committed_free_next = (committed_free | rel_mask) & ~commit_mask;
  end

  assign restore_mask = committed_free_next;

  // Clear bits for the entries the queue retires this cycle; a mispredict
  // suppresses them since the restore mask already covers those indices.
  always_comb begin
    clear = '0;
    if (!mispredict) begin
      for (int unsigned i = 0; i < NUM_DRAIN; i++) begin
        if (CNT_W'(i) < drain_cnt) clear[drain_idx[i]] = 1'b1;
      end
    end
  end

  // Committed mask and sticky error flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      committed_free  <= initial_mask;
      overflow_err    <= 1'b0;
      double_free_err <= 1'b0;
    end else begin
      committed_free <= committed_free_next;
      if ((|rel_valid) && !rel_ready) overflow_err <= 1'b1;
      if (dbl_hit) double_free_err <= 1'b1;
    end
  end

  a_no_release_commit_overlap: assert property (
    @(posedge clock) disable iff (reset) (rel_mask & commit_mask) == '0
  );

endmodule
